mem_lsu: RTL and testbench

Memory-stage load/store unit, directly downstream of the execute-stage ALU. Takes the ALU result as the effective address (or as a pass-through result), the rs2 value as store data, and the funct3 size code. Performs aligned byte/half/word accesses over a req/gnt/rvalid data-memory interface, then hands one result per instruction to writeback over a valid/ready handshake. Single outstanding transaction; no forwarding.

---
 rtl/lsu_pkg.sv | 23 ++
 rtl/lsu_align.sv | 66 ++++++
 rtl/mem_lsu.sv | 168 ++++++++++++++++
 tb/tb_mem_lsu.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the memory-stage load/store unit.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    RESP
  } lsu_state_e;

  typedef enum logic [1:0] {
    EXC_NONE     = 2'b00,
    EXC_MISALIGN = 2'b01,
    EXC_ILLEGAL  = 2'b10
  } lsu_exc_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables, store replication, access checks and
// load extraction with sign/zero extension.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int unsigned DWIDTH = 32
) (
  input  logic [1:0]        addr_i,
  input  logic [2:0]        funct3_i,
  input  logic              load_i,
  input  logic              store_i,
  input  logic [DWIDTH-1:0] rs2_i,
  input  logic [DWIDTH-1:0] rdata_i,
  output logic [3:0]        be_o,
  output logic [DWIDTH-1:0] wdata_o,
  output logic [DWIDTH-1:0] ldata_o,
  output logic              misalign_o,
  output logic              illegal_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    be_o    = 4'b1111;
    wdata_o = rs2_i;
    unique case (funct3_i[1:0])
      2'b00: begin
        be_o    = 4'b0001 << addr_i;
        wdata_o = {4{rs2_i[7:0]}};
      end
      2'b01: begin
        be_o    = 4'b0011 << addr_i;
        wdata_o = {2{rs2_i[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    illegal_o  = (load_i && (funct3_i == 3'b011 || funct3_i == 3'b110 || funct3_i == 3'b111))
              || (store_i && (funct3_i[2] || funct3_i == 3'b011));
    misalign_o = (load_i || store_i)
              && ((funct3_i[1:0] == 2'b01 && addr_i[0])
               || (funct3_i[1:0] == 2'b10 && addr_i != 2'b00));
  end

  always_comb begin
    byte_sel = rdata_i[7:0];
    unique case (addr_i)
      2'b00: byte_sel = rdata_i[7:0];
      2'b01: byte_sel = rdata_i[15:8];
      2'b10: byte_sel = rdata_i[23:16];
      2'b11: byte_sel = rdata_i[31:24];
    endcase
    half_sel = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    unique case (funct3_i)
      F3_B:    ldata_o = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   ldata_o = {24'h0, byte_sel};
      F3_H:    ldata_o = {{16{half_sel[15]}}, half_sel};
      F3_HU:   ldata_o = {16'h0, half_sel};
      default: ldata_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// Memory-stage load/store unit: one outstanding access over req/gnt/rvalid and a
// single registered result per instruction towards writeback.
module mem_lsu
  import lsu_pkg::*;
#(
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned AWIDTH = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              ex_valid_i,
  output logic              ex_ready_o,
  input  logic [AWIDTH-1:0] ex_res_i,
  input  logic [DWIDTH-1:0] ex_rs2_i,
  input  logic [2:0]        ex_funct3_i,
  input  logic              ex_load_i,
  input  logic              ex_store_i,
  input  logic [4:0]        ex_rd_i,
  input  logic              ex_rdwe_i,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [AWIDTH-1:0] dmem_addr_o,
  output logic [3:0]        dmem_be_o,
  output logic [DWIDTH-1:0] dmem_wdata_o,
  input  logic              dmem_gnt_i,
  input  logic              dmem_rvalid_i,
  input  logic [DWIDTH-1:0] dmem_rdata_i,
  output logic              wb_valid_o,
  input  logic              wb_ready_i,
  output logic [DWIDTH-1:0] wb_data_o,
  output logic [4:0]        wb_rd_o,
  output logic              wb_rdwe_o,
  output logic [1:0]        wb_exc_o
);

  lsu_state_e        state_q, state_d;
  lsu_exc_e          exc_q, exc_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic [DWIDTH-1:0] wdata_q, wdata_d, wb_data_q, wb_data_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [1:0]        lo_q, lo_d;
  logic [4:0]        rd_q, rd_d;
  logic              we_q, we_d, load_q, load_d, rdwe_q, rdwe_d;

  logic              in_idle;
  logic [3:0]        al_be;
  logic [DWIDTH-1:0] al_wdata, al_ldata;
  logic              al_misalign, al_illegal;

  assign in_idle = (state_q == IDLE);

  // In IDLE the checker looks at the incoming instruction; afterwards at the latched one.
  lsu_align #(
    .DWIDTH(DWIDTH)
  ) u_align (
    .addr_i    (in_idle ? ex_res_i[1:0] : lo_q),
    .funct3_i  (in_idle ? ex_funct3_i : funct3_q),
    .load_i    (in_idle ? ex_load_i : load_q),
    .store_i   (in_idle && ex_store_i),
    .rs2_i     (ex_rs2_i),
    .rdata_i   (dmem_rdata_i),
    .be_o      (al_be),
    .wdata_o   (al_wdata),
    .ldata_o   (al_ldata),
    .misalign_o(al_misalign),
    .illegal_o (al_illegal)
  );

  always_comb begin
    state_d   = state_q;
    exc_d     = exc_q;
    addr_d    = addr_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    wb_data_d = wb_data_q;
    funct3_d  = funct3_q;
    lo_d      = lo_q;
    rd_d      = rd_q;
    we_d      = we_q;
    load_d    = load_q;
    rdwe_d    = rdwe_q;
    unique case (state_q)
      IDLE: begin
        if (ex_valid_i) begin
          addr_d    = {ex_res_i[AWIDTH-1:2], 2'b00};
          be_d      = al_be;
          wdata_d   = al_wdata;
          funct3_d  = ex_funct3_i;
          lo_d      = ex_res_i[1:0];
          rd_d      = ex_rd_i;
          we_d      = ex_store_i;
          load_d    = ex_load_i;
          exc_d     = EXC_NONE;
          wb_data_d = '0;
          rdwe_d    = 1'b0;
          state_d   = RESP;
          if (!(ex_load_i || ex_store_i)) begin
            wb_data_d = DWIDTH'(ex_res_i);
            rdwe_d    = ex_rdwe_i;
          end else if (al_illegal) begin
            exc_d = EXC_ILLEGAL;
          end else if (al_misalign) begin
            exc_d = EXC_MISALIGN;
          end else begin
            rdwe_d  = ex_load_i && ex_rdwe_i;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (dmem_gnt_i) state_d = load_q ? WAIT : RESP;
      end
      WAIT: begin
        if (dmem_rvalid_i) begin
          wb_data_d = al_ldata;
          state_d   = RESP;
        end
      end
      RESP: begin
        if (wb_ready_i) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      exc_q     <= EXC_NONE;
      addr_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      wb_data_q <= '0;
      funct3_q  <= '0;
      lo_q      <= '0;
      rd_q      <= '0;
      we_q      <= 1'b0;
      load_q    <= 1'b0;
      rdwe_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      exc_q     <= exc_d;
      addr_q    <= addr_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      wb_data_q <= wb_data_d;
      funct3_q  <= funct3_d;
      lo_q      <= lo_d;
      rd_q      <= rd_d;
      we_q      <= we_d;
      load_q    <= load_d;
      rdwe_q    <= rdwe_d;
    end
  end

  assign ex_ready_o   = in_idle;
  assign dmem_req_o   = (state_q == REQ);
  assign dmem_we_o    = we_q;
  assign dmem_addr_o  = addr_q;
  assign dmem_be_o    = be_q;
  assign dmem_wdata_o = wdata_q;
  assign wb_valid_o   = (state_q == RESP);
  assign wb_data_o    = wb_data_q;
  assign wb_rd_o      = rd_q;
  assign wb_rdwe_o    = rdwe_q;
  assign wb_exc_o     = exc_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: non-memory ops, stores, loads, exceptions,
// writeback backpressure and reset while a load is outstanding.
module tb_mem_lsu;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        ex_valid_i, ex_ready_o;
  logic [31:0] ex_res_i, ex_rs2_i;
  logic [2:0]  ex_funct3_i;
  logic        ex_load_i, ex_store_i;
  logic [4:0]  ex_rd_i;
  logic        ex_rdwe_i;
  logic        dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_gnt_i, dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;
  logic        wb_valid_o, wb_ready_i;
  logic [31:0] wb_data_o;
  logic [4:0]  wb_rd_o;
  logic        wb_rdwe_o;
  logic [1:0]  wb_exc_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_i = ~clk_i;

  mem_lsu u_dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .ex_valid_i   (ex_valid_i),
    .ex_ready_o   (ex_ready_o),
    .ex_res_i     (ex_res_i),
    .ex_rs2_i     (ex_rs2_i),
    .ex_funct3_i  (ex_funct3_i),
    .ex_load_i    (ex_load_i),
    .ex_store_i   (ex_store_i),
    .ex_rd_i      (ex_rd_i),
    .ex_rdwe_i    (ex_rdwe_i),
    .dmem_req_o   (dmem_req_o),
    .dmem_we_o    (dmem_we_o),
    .dmem_addr_o  (dmem_addr_o),
    .dmem_be_o    (dmem_be_o),
    .dmem_wdata_o (dmem_wdata_o),
    .dmem_gnt_i   (dmem_gnt_i),
    .dmem_rvalid_i(dmem_rvalid_i),
    .dmem_rdata_i (dmem_rdata_i),
    .wb_valid_o   (wb_valid_o),
    .wb_ready_i   (wb_ready_i),
    .wb_data_o    (wb_data_o),
    .wb_rd_o      (wb_rd_o),
    .wb_rdwe_o    (wb_rdwe_o),
    .wb_exc_o     (wb_exc_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Presents one instruction for a single accepting edge.
  task automatic issue(input logic [31:0] res, input logic [31:0] rs2, input logic [2:0] f3,
                       input logic ld, input logic st, input logic [4:0] rd, input logic rdwe);
    ex_valid_i  = 1'b1;
    ex_res_i    = res;
    ex_rs2_i    = rs2;
    ex_funct3_i = f3;
    ex_load_i   = ld;
    ex_store_i  = st;
    ex_rd_i     = rd;
    ex_rdwe_i   = rdwe;
    tick();
    ex_valid_i  = 1'b0;
    ex_load_i   = 1'b0;
    ex_store_i  = 1'b0;
  endtask

  task automatic do_load(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                         input logic [31:0] rdata, input logic [31:0] exp);
    issue(addr, 32'h0, f3, 1'b1, 1'b0, 5'd7, 1'b1);
    check({tag, "_req"}, {31'h0, dmem_req_o}, 32'h1);
    dmem_gnt_i = 1'b1;
    tick();
    dmem_gnt_i    = 1'b0;
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = rdata;
    tick();
    dmem_rvalid_i = 1'b0;
    dmem_rdata_i  = 32'hDEAD_BEEF;
    check({tag, "_data"}, wb_data_o, exp);
    check({tag, "_valid"}, {31'h0, wb_valid_o}, 32'h1);
    check({tag, "_rdwe"}, {31'h0, wb_rdwe_o}, 32'h1);
    tick();
  endtask

  task automatic do_store(input string tag, input logic [31:0] addr, input logic [31:0] rs2,
                          input logic [2:0] f3, input logic [3:0] be, input logic [31:0] wd);
    issue(addr, rs2, f3, 1'b0, 1'b1, 5'd3, 1'b1);
    check({tag, "_be"}, {28'h0, dmem_be_o}, {28'h0, be});
    check({tag, "_wdata"}, dmem_wdata_o, wd);
    dmem_gnt_i = 1'b1;
    tick();
    dmem_gnt_i = 1'b0;
    check({tag, "_rdwe"}, {31'h0, wb_rdwe_o}, 32'h0);
    tick();
  endtask

  task automatic do_exc(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                        input logic ld, input logic [1:0] exc);
    issue(addr, 32'h1234_5678, f3, ld, ~ld, 5'd9, 1'b1);
    check({tag, "_valid"}, {31'h0, wb_valid_o}, 32'h1);
    check({tag, "_exc"}, {30'h0, wb_exc_o}, {30'h0, exc});
    check({tag, "_rdwe"}, {31'h0, wb_rdwe_o}, 32'h0);
    check({tag, "_data"}, wb_data_o, 32'h0);
    check({tag, "_noreq"}, {31'h0, dmem_req_o}, 32'h0);
    tick();
  endtask

  initial begin
    rst_ni        = 1'b0;
    ex_valid_i    = 1'b0;
    ex_res_i      = '0;
    ex_rs2_i      = '0;
    ex_funct3_i   = '0;
    ex_load_i     = 1'b0;
    ex_store_i    = 1'b0;
    ex_rd_i       = '0;
    ex_rdwe_i     = 1'b0;
    dmem_gnt_i    = 1'b0;
    dmem_rvalid_i = 1'b0;
    dmem_rdata_i  = '0;
    wb_ready_i    = 1'b1;

    #12;
    check("rst_ready", {31'h0, ex_ready_o}, 32'h1);
    check("rst_req", {31'h0, dmem_req_o}, 32'h0);
    check("rst_wbvalid", {31'h0, wb_valid_o}, 32'h0);
    check("rst_addr", dmem_addr_o, 32'h0);
    check("rst_exc", {30'h0, wb_exc_o}, 32'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();

    // Non-memory op
    issue(32'h0000_1234, 32'h0, 3'b000, 1'b0, 1'b0, 5'd5, 1'b1);
    check("alu_valid", {31'h0, wb_valid_o}, 32'h1);
    check("alu_data", wb_data_o, 32'h0000_1234);
    check("alu_rd", {27'h0, wb_rd_o}, 32'd5);
    check("alu_rdwe", {31'h0, wb_rdwe_o}, 32'h1);
    check("alu_noreq", {31'h0, dmem_req_o}, 32'h0);
    tick();
    check("alu_done", {31'h0, wb_valid_o}, 32'h0);
    check("alu_ready", {31'h0, ex_ready_o}, 32'h1);

    // SB with two stall cycles before grant
    issue(32'h0000_0103, 32'hAABB_CCDD, 3'b000, 1'b0, 1'b1, 5'd1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      check("sb_req", {31'h0, dmem_req_o}, 32'h1);
      check("sb_we", {31'h0, dmem_we_o}, 32'h1);
      check("sb_addr", dmem_addr_o, 32'h0000_0100);
      check("sb_be", {28'h0, dmem_be_o}, 32'h8);
      check("sb_wdata", dmem_wdata_o, 32'hDDDD_DDDD);
      check("sb_exready", {31'h0, ex_ready_o}, 32'h0);
      if (i == 2) dmem_gnt_i = 1'b1;
      tick();
    end
    dmem_gnt_i = 1'b0;
    check("sb_valid", {31'h0, wb_valid_o}, 32'h1);
    check("sb_rdwe", {31'h0, wb_rdwe_o}, 32'h0);
    check("sb_data", wb_data_o, 32'h0);
    check("sb_reqoff", {31'h0, dmem_req_o}, 32'h0);
    tick();

    do_store("sh", 32'h0000_0202, 32'h1122_3344, 3'b001, 4'b1100, 32'h3344_3344);
    do_store("sw", 32'h0000_0204, 32'h1122_3344, 3'b010, 4'b1111, 32'h1122_3344);

    do_load("lb", 32'h0000_0202, 3'b000, 32'h80F1_7F00, 32'hFFFF_FFF1);
    do_load("lbu", 32'h0000_0202, 3'b100, 32'h80F1_7F00, 32'h0000_00F1);
    do_load("lh", 32'h0000_0202, 3'b001, 32'h80F1_7F00, 32'hFFFF_80F1);
    do_load("lhu", 32'h0000_0202, 3'b101, 32'h80F1_7F00, 32'h0000_80F1);
    do_load("lb1", 32'h0000_0201, 3'b000, 32'h80F1_7F00, 32'h0000_007F);
    do_load("lw", 32'h0000_0200, 3'b010, 32'h80F1_7F00, 32'h80F1_7F00);

    do_exc("lw_mis", 32'h0000_0206, 3'b010, 1'b1, 2'b01);
    do_exc("ld_ill", 32'h0000_0200, 3'b011, 1'b1, 2'b10);
    do_exc("sh_mis", 32'h0000_0201, 3'b001, 1'b0, 2'b01);
    do_exc("st_ill", 32'h0000_0201, 3'b100, 1'b0, 2'b10);

    // Writeback backpressure on a completed load
    wb_ready_i = 1'b0;
    issue(32'h0000_0300, 32'h0, 3'b010, 1'b1, 1'b0, 5'd12, 1'b1);
    dmem_gnt_i = 1'b1;
    tick();
    dmem_gnt_i    = 1'b0;
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = 32'h1234_5678;
    tick();
    dmem_rvalid_i = 1'b0;
    dmem_rdata_i  = 32'h0;
    for (int i = 0; i < 4; i++) begin
      check("bp_valid", {31'h0, wb_valid_o}, 32'h1);
      check("bp_data", wb_data_o, 32'h1234_5678);
      check("bp_rd", {27'h0, wb_rd_o}, 32'd12);
      check("bp_exready", {31'h0, ex_ready_o}, 32'h0);
      tick();
    end
    wb_ready_i = 1'b1;
    check("bp_hold", {31'h0, wb_valid_o}, 32'h1);
    tick();
    check("bp_release", {31'h0, wb_valid_o}, 32'h0);
    check("bp_idle", {31'h0, ex_ready_o}, 32'h1);

    // Reset while waiting for read data; the late response must be dropped
    issue(32'h0000_0400, 32'h0, 3'b010, 1'b1, 1'b0, 5'd4, 1'b1);
    dmem_gnt_i = 1'b1;
    tick();
    dmem_gnt_i = 1'b0;
    check("mr_wait", {31'h0, ex_ready_o}, 32'h0);
    #2;
    rst_ni = 1'b0;
    #1;
    check("mr_async_ready", {31'h0, ex_ready_o}, 32'h1);
    check("mr_async_req", {31'h0, dmem_req_o}, 32'h0);
    check("mr_async_valid", {31'h0, wb_valid_o}, 32'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = 32'hCAFE_F00D;
    tick();
    dmem_rvalid_i = 1'b0;
    check("mr_stale_valid", {31'h0, wb_valid_o}, 32'h0);
    check("mr_stale_ready", {31'h0, ex_ready_o}, 32'h1);
    tick();
    check("mr_stale_valid2", {31'h0, wb_valid_o}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
